// File: rtl/led_message_scroller_pkg.sv
// Shared constants and message ROM for the LED message scroller.
package led_scroller_pkg;

  localparam int unsigned MSG_LEN = 16;
  localparam int unsigned CHAR_W  = 4;
  localparam int unsigned POS_W   = 4;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [POS_W-1:0]  pos_t;

  // Message ROM, entry i at MSG[i]; default content MSG[i] = i.
  localparam logic [MSG_LEN-1:0][CHAR_W-1:0] MSG = 64'hFEDC_BA98_7654_3210;

  // Character at window offset 'ofs' from start position 'p' (wraps mod 16).
  function automatic char_t msg_at(input pos_t p, input pos_t ofs);
    pos_t idx;
    idx = p + ofs;
    return MSG[idx];
  endfunction

endpackage

// File: rtl/led_message_scroller_debouncer.sv
// Button debouncer: 2-flop synchronizer, stability counter, rising-edge press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_press;
  logic             w_btn_s;

  assign w_btn_s = r_sync[1];
  assign o_press = r_press;

  // Synchronize, count disagreeing cycles, toggle the accepted level when the count completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= 2'b00;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_button};
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      if (w_btn_s != r_stable) begin
        if (r_cnt == CNT_MAX) begin
          r_stable <= ~r_stable;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_message_scroller.sv
// Four-character scrolling window over the message ROM, advanced by debounced presses.
// Optional feature macro: SCROLL_AUTO_EN adds a periodic auto-advance every AUTO_PERIOD cycles.
module led_message_scroller
  import led_scroller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic [3:0] pos,
  output logic       update
);

  logic  w_press;
  logic  w_tick;
  logic  w_advance;
  pos_t  w_next_pos;
  pos_t  r_pos;
  char_t r_char3, r_char2, r_char1, r_char0;
  logic  r_update;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .i_button(button),
    .o_press (w_press)
  );

`ifdef SCROLL_AUTO_EN
  localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] r_auto_cnt;

  assign w_tick = (r_auto_cnt == AUTO_MAX);

  // Free-running auto timer; a press restarts the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto_cnt <= '0;
    end else if (w_press || w_tick) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end
  end
`else
  assign w_tick = 1'b0;
`endif

  // Press and tick together still advance by one.
  assign w_advance  = w_press | w_tick;
  assign w_next_pos = r_pos + POS_W'(1);

  // Window position, character registers and update strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos    <= '0;
      r_char3  <= MSG[0];
      r_char2  <= MSG[1];
      r_char1  <= MSG[2];
      r_char0  <= MSG[3];
      r_update <= 1'b0;
    end else begin
      r_update <= w_advance;
      if (w_advance) begin
        r_pos   <= w_next_pos;
        r_char3 <= msg_at(w_next_pos, POS_W'(0));
        r_char2 <= msg_at(w_next_pos, POS_W'(1));
        r_char1 <= msg_at(w_next_pos, POS_W'(2));
        r_char0 <= msg_at(w_next_pos, POS_W'(3));
      end
    end
  end

  assign pos    = r_pos;
  assign char3  = r_char3;
  assign char2  = r_char2;
  assign char1  = r_char1;
  assign char0  = r_char0;
  assign update = r_update;

endmodule

// File: tb/tb_led_message_scroller.sv
// Directed testbench for led_message_scroller (DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 10).
`timescale 1ns/1ps
module tb_led_message_scroller;

  logic       clk;
  logic       reset;
  logic       button;
  logic [3:0] char3, char2, char1, char0, pos;
  logic       update;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  led_message_scroller #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .char3 (char3),
    .char2 (char2),
    .char1 (char1),
    .char0 (char0),
    .pos   (pos),
    .update(update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic do_reset();
    reset  = 1'b1;
    button = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clean press and release: high 10 cycles, low 10 cycles.
  task automatic press_once();
    @(negedge clk);
    button = 1'b1;
    repeat (10) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    int u0;
    reset  = 1'b1;
    button = 1'b0;
    #10000;
    checks++;
    if ({pos, char3, char2, char1, char0, update} !== {4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got pos=%h chars=%h%h%h%h upd=%b exp pos=0 chars=0123 upd=0",
               pos, char3, char2, char1, char0, update);
    end
    @(negedge clk);
    reset = 1'b0;
    u0 = upd_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (upd_cnt !== u0 || pos !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle got updates=%0d pos=%h exp updates=0 pos=0", upd_cnt - u0, pos);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (update !== (k == 7)) begin
        errors++;
        $display("FAIL single_press_update edge E+%0d got %b exp %b", k, update, (k == 7));
      end
    end
    button = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({pos, char3, char2, char1, char0} !== {4'h1, 4'h1, 4'h2, 4'h3, 4'h4}) begin
      errors++;
      $display("FAIL single_press_window got pos=%h chars=%h%h%h%h exp pos=1 chars=1234",
               pos, char3, char2, char1, char0);
    end
  endtask

  task automatic test_bounce();
    int u0;
    do_reset();
    u0 = upd_cnt;
    for (int k = 0; k < 40; k++) begin
      button = ((k / 3) % 2 == 0);
      @(negedge clk);
    end
    button = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (upd_cnt !== u0 || pos !== 4'h0 || {char3, char2, char1, char0} !== 16'h0123) begin
      errors++;
      $display("FAIL bounce got updates=%0d pos=%h chars=%h%h%h%h exp updates=0 pos=0 chars=0123",
               upd_cnt - u0, pos, char3, char2, char1, char0);
    end
  endtask

  task automatic test_wrap();
    int u0;
    logic [3:0] exp_pos;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      u0 = upd_cnt;
      press_once();
      exp_pos = 4'(i);
      checks++;
      if (pos !== exp_pos || upd_cnt - u0 != 1) begin
        errors++;
        $display("FAIL wrap_press_%0d got pos=%h updates=%0d exp pos=%h updates=1",
                 i, pos, upd_cnt - u0, exp_pos);
      end
      if (i == 14) begin
        checks++;
        if ({char3, char2, char1, char0} !== 16'hEF01) begin
          errors++;
          $display("FAIL wrap_chars_pos14 got %h%h%h%h exp EF01", char3, char2, char1, char0);
        end
      end
    end
    checks++;
    if ({char3, char2, char1, char0} !== 16'h0123) begin
      errors++;
      $display("FAIL wrap_chars_final got %h%h%h%h exp 0123", char3, char2, char1, char0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) press_once();
    checks++;
    if (pos !== 4'h5) begin
      errors++;
      $display("FAIL reset_mid_setup got pos=%h exp 5", pos);
    end
    button = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({pos, char3, char2, char1, char0, update} !== {4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async got pos=%h chars=%h%h%h%h upd=%b exp pos=0 chars=0123 upd=0",
               pos, char3, char2, char1, char0, update);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (update !== (k == 7)) begin
        errors++;
        $display("FAIL reset_mid_relatency edge R+%0d got %b exp %b", k, update, (k == 7));
      end
    end
    button = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (pos !== 4'h1) begin
      errors++;
      $display("FAIL reset_mid_pos got %h exp 1", pos);
    end
  endtask

`ifdef SCROLL_AUTO_EN
  task automatic test_auto();
    logic [3:0] exp_pos;
    logic       exp_upd;
    do_reset();
    exp_pos = 4'h0;
    for (int k = 0; k < 56; k++) begin
      @(posedge clk);
      #1;
      exp_upd = (k == 9) || (k == 19) || (k == 29) || (k == 39) || (k == 49);
      if (exp_upd) exp_pos = exp_pos + 4'h1;
      checks++;
      if (update !== exp_upd || pos !== exp_pos) begin
        errors++;
        $display("FAIL auto edge R+%0d got upd=%b pos=%h exp upd=%b pos=%h",
                 k, update, pos, exp_upd, exp_pos);
      end
      if (k == 31) button = 1'b1;
      if (k == 45) button = 1'b0;
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_reset_mid();
`ifdef SCROLL_AUTO_EN
    test_auto();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_message_scroller.md
# led_message_scroller

Upstream feeder for the four-digit LED driver. Debounces the board push-button and advances a 4-character window over a fixed 16-entry message ROM, one position per press. Drives the four 4-bit character codes the driver multiplexes onto an3..an0 and the a..g/dp segments. Optionally also advances automatically on a programmable timer.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive synchronized-stable cycles required to accept a button level change (10 ms at 100 MHz); benches override to 4.
- AUTO_PERIOD, default 50000000: cycles between automatic advances (only with SCROLL_AUTO_EN).
- clk  in  1  single system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- button  in  1  raw, asynchronous, bouncing push-button, active-high.
- char3  out  4  leftmost digit code (drives the an3 position).
- char2  out  4  digit code for the an2 position.
- char1  out  4  digit code for the an1 position.
- char0  out  4  rightmost digit code (drives the an0 position).
- pos  out  4  current window start index into the message, 0..15.
- update  out  1  one-cycle pulse in the cycle the char outputs take new values.

## Operation
- Message ROM MSG[0..15]: 16 constant 4-bit codes from the shared package; default content MSG[i] = i.
- Window: char3 = MSG[pos], char2 = MSG[(pos+1) mod 16], char1 = MSG[(pos+2) mod 16], char0 = MSG[(pos+3) mod 16]; all registered.
- Debounce path: 2-flop synchronizer -> btn_s; counter cnt increments each cycle btn_s != stable, clears when equal; when cnt reaches DEBOUNCE_CYCLES-1 with btn_s != stable, stable toggles and cnt clears. Any single-cycle agreement restarts the count.
- press: registered one-cycle pulse on each 0->1 transition of stable; 1->0 transitions produce nothing.
- Advance (press, or auto tick): pos <= pos+1 modulo 16 (15 wraps to 0), char outputs reload from the new pos, update = 1 for exactly that cycle.
- Press and auto tick in the same cycle: one advance of 1, never 2.
- Holding the button produces exactly one advance; repeat needs a release accepted by the debouncer.

## Timing
- Reset values: pos = 0, char3..char0 = MSG[0..3] (0,1,2,3 by default), update = 0, stable = 0, cnt = 0, synchronizer = 0, auto counter = 0.
- Reset is asynchronous assert, outputs take reset values without a clock edge; deassertion is sampled on the next clk edge; reset mid-count discards any partial debounce or auto count.
- Latency: button high and clean from edge E -> btn_s high after edge E+1 -> stable high at edge E+1+DEBOUNCE_CYCLES -> press at edge E+2+DEBOUNCE_CYCLES -> pos/chars/update at edge E+3+DEBOUNCE_CYCLES.
- Glitch of fewer than DEBOUNCE_CYCLES synchronized cycles: no press, no output change.
- update is high one cycle per advance; chars are stable in all other cycles.

## Configuration
- SCROLL_AUTO_EN defined: free-running counter 0..AUTO_PERIOD-1; tick when counter = AUTO_PERIOD-1, counter wraps to 0; an accepted press also clears the counter, so the next auto advance comes AUTO_PERIOD cycles after that press.
- SCROLL_AUTO_EN undefined: no auto counter synthesized, AUTO_PERIOD ignored; advances only on press.

## Structure
- Package led_scroller_pkg: MSG_LEN = 16, CHAR_W = 4, POS_W = 4, message ROM constant array, char code typedef.
- Sub-module button_debouncer (synchronizer + counter + rising-edge press pulse), parameter DEBOUNCE_CYCLES; top holds pos register, window mux, auto timer.

## Test plan
- Reset held 10000 ns then released, no button -> pos = 0, chars = 0,1,2,3, update never asserts.
- DEBOUNCE_CYCLES = 4, button high 20 cycles -> exactly one update, at edge E+7; pos = 1, chars = 1,2,3,4.
- Button bounces 3-cycle high/low pulses for 40 cycles, then stays low -> no update, pos stays 0.
- 16 clean presses from reset -> pos sequence 1..15,0; at pos = 14 chars = E,F,0,1; final chars = 0,1,2,3.
- SCROLL_AUTO_EN, AUTO_PERIOD = 10, no button -> update every 10 cycles; press accepted at cycle coinciding with tick -> single advance, next tick 10 cycles later.
- Assert reset mid-debounce (cnt = 2) and with pos = 5 -> outputs return to reset values immediately; post-release press needs full DEBOUNCE_CYCLES.
